// File: rtl/nanorv32_sim_monitor_pkg.sv
// Shared types and constants for the nanorv32 simulation monitor: status codes,
// the newline byte that terminates a console line, and the channel-id width helper.
package nanorv32_sim_monitor_pkg;

   typedef enum logic [2:0] {
      ST_RUN          = 3'd0,
      ST_PASS         = 3'd1,
      ST_FAIL         = 3'd2,
      ST_FAIL_UNKNOWN = 3'd3,
      ST_ILLEGAL      = 3'd4,
      ST_TIMEOUT      = 3'd5
   } status_e;

   localparam logic [7:0] CHR_NEWLINE = 8'h0A;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nanorv32_mon_linebuf.sv
// One console channel: circular byte buffer whose bytes become drainable only once
// their line is committed (newline, buffer filling up, or final flush at end of test).
module nanorv32_mon_linebuf
   import nanorv32_sim_monitor_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       flush_i,
   input  logic       pop_i,
   output logic       has_committed_o,
   output logic [7:0] rd_data_o,
   output logic       rd_last_o,
   output logic       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [DEPTH-1:0] last_q;
   logic [PW-1:0] wr_q, commit_q, rd_q;
   logic          overflow_q;
   logic          full, fills, push_ok, push_last;
   logic [AW-1:0] wr_idx, tail_idx;

   assign wr_idx    = wr_q[AW-1:0];
   assign tail_idx  = wr_idx - AW'(1);
   assign full      = (wr_q - rd_q) == PW'(DEPTH);
   assign fills     = (wr_q - rd_q) == PW'(DEPTH - 1);
   assign push_ok   = push_i && !full;
   // A byte closes its line on newline, when it fills the buffer, or on final flush.
   assign push_last = (data_i == CHR_NEWLINE) || fills || flush_i;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_idx]  <= data_i;
         last_q[wr_idx] <= push_last;
      end else if (flush_i && (commit_q != wr_q)) begin
         last_q[tail_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q       <= '0;
         commit_q   <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_q <= wr_q + PW'(1);
         if (push_ok && push_last) commit_q <= wr_q + PW'(1);
         else if (flush_i)         commit_q <= wr_q;
         if (pop_i) rd_q <= rd_q + PW'(1);
         if (push_i && full) overflow_q <= 1'b1;
      end
   end

   assign has_committed_o = (commit_q != rd_q);
   assign rd_data_o       = mem_q[rd_q[AW-1:0]];
   assign rd_last_o       = last_q[rd_q[AW-1:0]];
   assign overflow_o      = overflow_q;

endmodule

// File: rtl/nanorv32_sim_monitor.sv
// End-of-test and console monitor: sticky status FSM with timeout, per-channel printf
// line buffers, and a line-locked round-robin arbiter onto a single character stream.
module nanorv32_sim_monitor
   import nanorv32_sim_monitor_pkg::*;
#(
   parameter int          NUM_CH      = 2,
   parameter int          LINE_DEPTH  = 64,
   parameter logic [31:0] PASS_PC     = 32'h00000100,
   parameter logic [31:0] PRINTF_PC   = 32'h00000088,
   parameter logic [31:0] PASS_CODE   = 32'hCAFFE000,
   parameter logic [31:0] FAIL_CODE   = 32'hDEADD000,
   parameter int unsigned TIMEOUT_CYC = 10000000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [31:0]                     pc_exe,
   input  logic                            inst_ret,
   input  logic                            illegal_instruction,
   input  logic [31:0]                     a0,
   output logic                            chr_valid,
   output logic [7:0]                      chr_data,
   output logic [ch_width(NUM_CH)-1:0]     chr_ch,
   output logic                            chr_last,
   input  logic                            chr_ready,
   output logic [2:0]                      status,
   output logic                            done,
   output logic [NUM_CH-1:0]               overflow,
   output logic [31:0]                     retired_cnt
);

   localparam int          CH_W    = ch_width(NUM_CH);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   status_e     state_q, state_d;
   logic [31:0] to_cnt_q, retired_q;
   logic        timeout_hit, final_flush, in_run;

   assign in_run      = (state_q == ST_RUN);
   assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      if (in_run) begin
         if (illegal_instruction) begin
            state_d = ST_ILLEGAL;
         end else if (inst_ret && (pc_exe == PASS_PC)) begin
            if (a0 == PASS_CODE)      state_d = ST_PASS;
            else if (a0 == FAIL_CODE) state_d = ST_FAIL;
            else                      state_d = ST_FAIL_UNKNOWN;
         end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
         end
      end
   end

   assign final_flush = in_run && (state_d != ST_RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         to_cnt_q  <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (in_run) begin
            to_cnt_q  <= to_cnt_q + 32'd1;
            retired_q <= retired_q + {31'b0, inst_ret};
         end
      end
   end

   assign status      = state_q;
   assign done        = !in_run;
   assign retired_cnt = retired_q;

   logic [NUM_CH-1:0] has_c, last_c, pop_c;
   logic [7:0]        rd_data [NUM_CH];
   logic              pop_any;
   logic [CH_W-1:0]   sel, idx, cur_q, rr_q;
   logic              lock_q, any_c;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign pop_c[k] = pop_any && (sel == CH_W'(k));
      nanorv32_mon_linebuf #(.DEPTH(LINE_DEPTH)) u_buf (
         .clk             (clk),
         .rst             (rst),
         .push_i          (in_run && inst_ret && (pc_exe == PRINTF_PC + 32'(4 * k))),
         .data_i          (a0[7:0]),
         .flush_i         (final_flush),
         .pop_i           (pop_c[k]),
         .has_committed_o (has_c[k]),
         .rd_data_o       (rd_data[k]),
         .rd_last_o       (last_c[k]),
         .overflow_o      (overflow[k])
      );
   end

   // Lowest round-robin offset from rr_q wins; a presented line stays granted until its last byte pops.
   always_comb begin
      sel   = cur_q;
      any_c = 1'b0;
      idx   = '0;
      if (lock_q) begin
         any_c = has_c[cur_q];
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(rr_q) + i) % NUM_CH);
            if (has_c[idx]) begin
               sel   = idx;
               any_c = 1'b1;
            end
         end
      end
   end

   // Handshake: a byte transfers on a clock edge where chr_valid && chr_ready; while
   // chr_valid && !chr_ready, chr_data/chr_ch/chr_last hold and chr_valid stays high.
   assign chr_valid = any_c;
   assign chr_ch    = sel;
   assign chr_data  = any_c ? rd_data[sel] : 8'h00;
   assign chr_last  = any_c && last_c[sel];
   assign pop_any   = chr_valid && chr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
         cur_q  <= '0;
         rr_q   <= '0;
      end else if (chr_valid) begin
         cur_q <= sel;
         if (chr_ready && chr_last) begin
            lock_q <= 1'b0;
            rr_q   <= CH_W'((int'(sel) + 1) % NUM_CH);
         end else begin
            lock_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nanorv32_sim_monitor.sv
// Bench for nanorv32_sim_monitor: status decisions, timeout, and printf line streams
// checked against an expected-byte queue of {channel, data, last}.
module tb_nanorv32_sim_monitor;

   localparam logic [31:0] PASS_PC   = 32'h00000100;
   localparam logic [31:0] PRINTF_PC = 32'h00000088;
   localparam logic [31:0] PASS_CODE = 32'hCAFFE000;
   localparam logic [31:0] FAIL_CODE = 32'hDEADD000;

   logic        clk = 1'b0, rst = 1'b1, inst_ret = 1'b0, illegal_instruction = 1'b0, chr_ready = 1'b0;
   logic [31:0] pc_exe = '0, a0 = '0;
   logic        chr_valid, chr_last, done;
   logic [7:0]  chr_data;
   logic [0:0]  chr_ch;
   logic [2:0]  status;
   logic [1:0]  overflow;
   logic [31:0] retired_cnt;

   int tests_run = 0;
   int failures  = 0;
   logic [9:0] exp_q[$];
   logic [9:0] sb_e, held_v;
   logic       held = 1'b0;

   nanorv32_sim_monitor #(
      .NUM_CH(2), .LINE_DEPTH(4), .PASS_PC(PASS_PC), .PRINTF_PC(PRINTF_PC),
      .PASS_CODE(PASS_CODE), .FAIL_CODE(FAIL_CODE), .TIMEOUT_CYC(50)
   ) dut (
      .clk(clk), .rst(rst), .pc_exe(pc_exe), .inst_ret(inst_ret),
      .illegal_instruction(illegal_instruction), .a0(a0),
      .chr_valid(chr_valid), .chr_data(chr_data), .chr_ch(chr_ch), .chr_last(chr_last),
      .chr_ready(chr_ready), .status(status), .done(done), .overflow(overflow),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted byte must match the head of exp_q; held bytes must not change.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            tests_run++;
            if (!chr_valid || ({chr_ch, chr_data, chr_last} !== held_v)) begin
               failures++;
               $display("FAIL hold_stable: got valid=%0b {ch,data,last}=%h, want valid=1 %h",
                        chr_valid, {chr_ch, chr_data, chr_last}, held_v);
            end
         end
         if (chr_valid && chr_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got ch=%0d data=%h last=%0b, want no byte",
                        chr_ch, chr_data, chr_last);
            end else begin
               sb_e = exp_q.pop_front();
               if ({chr_ch, chr_data, chr_last} !== sb_e) begin
                  failures++;
                  $display("FAIL sb_byte: got ch=%0d data=%h last=%0b, want ch=%0d data=%h last=%0b",
                           chr_ch, chr_data, chr_last, sb_e[9], sb_e[8:1], sb_e[0]);
               end
            end
         end
         held   = chr_valid && !chr_ready;
         held_v = {chr_ch, chr_data, chr_last};
      end
   end

   task automatic do_reset();
      rst = 1'b1; inst_ret = 1'b0; illegal_instruction = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] d, input logic ill);
      inst_ret = 1'b1; pc_exe = pc; a0 = d; illegal_instruction = ill;
      @(posedge clk); #1;
      inst_ret = 1'b0; pc_exe = '0; a0 = '0; illegal_instruction = 1'b0;
   endtask

   task automatic push_chr(input int ch, input logic [7:0] b);
      retire(PRINTF_PC + 32'(4 * ch), {24'h0, b}, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input int budget, input bit rnd);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         chr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      chr_ready = 1'b0;
      retire(32'h10, 32'h0, 1'b0);
      push_chr(0, "Q");
      push_chr(0, 8'h0A);
      do_reset();
      tests_run++; if (status !== 3'd0) begin failures++; $display("FAIL reset_status: got %0d want 0", status); end
      tests_run++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
      tests_run++; if ({chr_valid, chr_data, chr_last, chr_ch} !== 11'h0) begin failures++;
         $display("FAIL reset_chr: got valid=%0b data=%h last=%0b ch=%0d want all 0", chr_valid, chr_data, chr_last, chr_ch); end
      tests_run++; if (overflow !== 2'b00) begin failures++; $display("FAIL reset_overflow: got %b want 00", overflow); end
      tests_run++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL reset_retired: got %0d want 0", retired_cnt); end
      chr_ready = 1'b1;
      idle(3);
      chr_ready = 1'b0;
   endtask

   task automatic test_pass();
      do_reset();
      retire(32'h10, 32'h0, 1'b0);
      retire(32'h14, 32'h0, 1'b0);
      tests_run++; if ({status, retired_cnt} !== {3'd0, 32'd2}) begin failures++;
         $display("FAIL pass_pre: got status=%0d retired=%0d want 0/2", status, retired_cnt); end
      retire(PASS_PC, PASS_CODE, 1'b0);
      tests_run++; if ({status, done, retired_cnt} !== {3'd1, 1'b1, 32'd3}) begin failures++;
         $display("FAIL pass_status: got status=%0d done=%0b retired=%0d want 1/1/3", status, done, retired_cnt); end
      retire(PASS_PC, FAIL_CODE, 1'b1);
      retire(32'h18, 32'h0, 1'b0);
      tests_run++; if ({status, retired_cnt} !== {3'd1, 32'd3}) begin failures++;
         $display("FAIL pass_sticky: got status=%0d retired=%0d want 1/3", status, retired_cnt); end
   endtask

   task automatic test_fail();
      logic [31:0] codes [3] = '{FAIL_CODE, 32'h12345678, PASS_CODE};
      logic        ills  [3] = '{1'b0, 1'b0, 1'b1};
      logic [2:0]  want  [3] = '{3'd2, 3'd3, 3'd4};
      for (int i = 0; i < 3; i++) begin
         do_reset();
         retire(PASS_PC, codes[i], ills[i]);
         tests_run++; if ({status, done} !== {want[i], 1'b1}) begin failures++;
            $display("FAIL fail_status[%0d]: got status=%0d done=%0b want %0d/1", i, status, done, want[i]); end
      end
   endtask

   task automatic test_printf();
      do_reset();
      chr_ready = 1'b1;
      exp_q.push_back({1'b0, 8'h48, 1'b0}); push_chr(0, 8'h48);
      tests_run++; if (chr_valid !== 1'b0) begin failures++; $display("FAIL printf_early_H: got valid=%0b want 0", chr_valid); end
      exp_q.push_back({1'b0, 8'h69, 1'b0}); push_chr(0, 8'h69);
      tests_run++; if (chr_valid !== 1'b0) begin failures++; $display("FAIL printf_early_i: got valid=%0b want 0", chr_valid); end
      exp_q.push_back({1'b0, 8'h0A, 1'b1}); push_chr(0, 8'h0A);
      tests_run++; if ({chr_valid, chr_data, chr_last} !== {1'b1, 8'h48, 1'b0}) begin failures++;
         $display("FAIL printf_latency: got valid=%0b data=%h last=%0b want 1/48/0", chr_valid, chr_data, chr_last); end
      drain(8, 1'b0);
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL printf_drain: got %0d left want 0", exp_q.size()); end
      chr_ready = 1'b0;
   endtask

   task automatic test_multi_channel();
      int         chs [6] = '{0, 1, 0, 1, 0, 1};
      logic [7:0] bs  [6] = '{8'h41, 8'h43, 8'h42, 8'h44, 8'h0A, 8'h0A};
      do_reset();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 6; i++)
            if (chs[i] == c) exp_q.push_back({1'(c), bs[i], bs[i] == 8'h0A});
      for (int i = 0; i < 6; i++) begin
         chr_ready = 1'($urandom_range(0, 1));
         push_chr(chs[i], bs[i]);
      end
      drain(35, 1'b1);
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL multi_drain: got %0d left want 0", exp_q.size()); end
      chr_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      do_reset();
      chr_ready = 1'b0;
      exp_q.push_back({1'b0, 8'h41, 1'b0}); exp_q.push_back({1'b0, 8'h0A, 1'b1});
      exp_q.push_back({1'b1, 8'h43, 1'b0}); exp_q.push_back({1'b1, 8'h0A, 1'b1});
      exp_q.push_back({1'b0, 8'h42, 1'b0}); exp_q.push_back({1'b0, 8'h0A, 1'b1});
      push_chr(0, 8'h41); push_chr(0, 8'h0A); push_chr(0, 8'h42); push_chr(0, 8'h0A);
      push_chr(1, 8'h43); push_chr(1, 8'h0A);
      drain(12, 1'b0);
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_drain: got %0d left want 0", exp_q.size()); end
      tests_run++; if (overflow !== 2'b00) begin failures++; $display("FAIL rr_overflow: got %b want 00", overflow); end
      chr_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      chr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, 8'(8'h61 + i), i == 3});
         push_chr(0, 8'(8'h61 + i));
      end
      tests_run++; if ({overflow, chr_valid, chr_data} !== {2'b00, 1'b1, 8'h61}) begin failures++;
         $display("FAIL ovf_fill: got ovf=%b valid=%0b data=%h want 00/1/61", overflow, chr_valid, chr_data); end
      push_chr(0, 8'h65); push_chr(0, 8'h66);
      tests_run++; if (overflow !== 2'b01) begin failures++; $display("FAIL ovf_flag: got %b want 01", overflow); end
      drain(10, 1'b0);
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain: got %0d left want 0", exp_q.size()); end
      tests_run++; if (overflow !== 2'b01) begin failures++; $display("FAIL ovf_sticky: got %b want 01", overflow); end
      chr_ready = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      chr_ready = 1'b0;
      exp_q.push_back({1'b1, 8'h5A, 1'b1});
      push_chr(1, 8'h5A);
      idle(48);
      tests_run++; if ({status, chr_valid} !== {3'd0, 1'b0}) begin failures++;
         $display("FAIL timeout_early: got status=%0d valid=%0b want 0/0", status, chr_valid); end
      idle(1);
      tests_run++; if ({status, done} !== {3'd5, 1'b1}) begin failures++;
         $display("FAIL timeout_status: got status=%0d done=%0b want 5/1", status, done); end
      tests_run++; if ({chr_valid, chr_ch, chr_data, chr_last} !== {1'b1, 1'b1, 8'h5A, 1'b1}) begin failures++;
         $display("FAIL timeout_flush: got valid=%0b ch=%0d data=%h last=%0b want 1/1/5a/1", chr_valid, chr_ch, chr_data, chr_last); end
      drain(5, 1'b0);
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL timeout_drain: got %0d left want 0", exp_q.size()); end
      tests_run++; if (retired_cnt !== 32'd1) begin failures++; $display("FAIL timeout_retired: got %0d want 1", retired_cnt); end
      chr_ready = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      chr_ready = 1'b0;
      exp_q.push_back({1'b0, 8'h78, 1'b0});
      push_chr(0, 8'h78); push_chr(0, 8'h79); push_chr(0, 8'h0A); push_chr(1, 8'h71);
      chr_ready = 1'b1;
      idle(1);
      chr_ready = 1'b0;
      tests_run++; if ({chr_valid, chr_data} !== {1'b1, 8'h79}) begin failures++;
         $display("FAIL middrain_next: got valid=%0b data=%h want 1/79", chr_valid, chr_data); end
      do_reset();
      chr_ready = 1'b1;
      idle(4);
      tests_run++; if ({chr_valid, overflow} !== 3'b000) begin failures++;
         $display("FAIL middrain_cleared: got valid=%0b ovf=%b want 0/00", chr_valid, overflow); end
      exp_q.push_back({1'b0, 8'h6B, 1'b0}); push_chr(0, 8'h6B);
      exp_q.push_back({1'b0, 8'h0A, 1'b1}); push_chr(0, 8'h0A);
      drain(6, 1'b0);
      tests_run++; if (exp_q.size() != 0) begin failures++; $display("FAIL middrain_after: got %0d left want 0", exp_q.size()); end
      chr_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_printf();
      test_multi_channel();
      test_round_robin();
      test_overflow();
      test_timeout();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
